// File: rtl/psum_out_scheduler.sv
// Round-robin, word-granular sequencer draining PE psum lanes into the 1-bit output packer.
// Optional zero padding of the final partial word is enabled by defining PSUM_SCHED_PAD_EN.
module psum_out_scheduler #(
  parameter int NUM_LANES    = 4,
  parameter int WORD_BITS    = 32,
  parameter int CREDIT_DEPTH = 8,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic [1:0]           cfg_operation,
  input  logic [LEN_WIDTH-1:0] cfg_bits_per_lane,
  input  logic [NUM_LANES-1:0] lane_valid,
  input  logic [NUM_LANES-1:0] lane_data,
  output logic [NUM_LANES-1:0] lane_ready,
  input  logic                 word_consumed,
  output logic [1:0]           pk_operation,
  output logic                 pk_in_valid,
  output logic                 pk_in_data,
  output logic                 pk_layer_finish,
  output logic                 busy,
  output logic                 done
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int IDX_W  = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int CRED_W = $clog2(CREDIT_DEPTH + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORD_BITS - 1);
  localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(CREDIT_DEPTH);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_FINISH = 3'd3
`ifdef PSUM_SCHED_PAD_EN
    , ST_PAD  = 3'd4
`endif
  } state_t;

  state_t               state_r;
  logic [LEN_WIDTH-1:0] rem_r [NUM_LANES];
  logic [IDX_W-1:0]     idx_r;
  logic [CRED_W-1:0]    credit_r;
  logic [LANE_W-1:0]    rr_ptr_r;
  logic [LANE_W-1:0]    grant_r;
  logic                 grant_valid_r;
  logic [1:0]           pk_operation_r;
  logic                 pk_in_valid_r;
  logic                 pk_in_data_r;
  logic                 pk_layer_finish_r;
  logic                 busy_r;
  logic                 done_r;

  logic [NUM_LANES-1:0] lane_ready_s;
  logic                 transfer_s;
  logic                 bit_s;
  logic                 all_zero_s;
  logic                 win_found_s;
  logic [LANE_W-1:0]    win_lane_s;
  logic [LANE_W-1:0]    cand_s;
  logic                 hit_s;
  logic                 credit_dec_s;
  logic [CRED_W-1:0]    credit_next_s;

  // lane_ready is a pure decode of registered state, so no input reaches it combinationally
  always_comb begin
    all_zero_s = 1'b1;
    for (int g = 0; g < NUM_LANES; g++) begin
      lane_ready_s[g] = (state_r == ST_ISSUE) && grant_valid_r && (grant_r == LANE_W'(g)) &&
                        (rem_r[g] != '0) && ((idx_r != '0) || (credit_r != '0));
      all_zero_s = all_zero_s & (rem_r[g] == '0);
    end
    transfer_s = |(lane_valid & lane_ready_s);
    bit_s      = lane_data[grant_r];
  end

  // round-robin search starting at rr_ptr for a valid lane that still owes bits
  always_comb begin
    win_found_s = 1'b0;
    win_lane_s  = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand_s      = LANE_W'((int'(rr_ptr_r) + i) % NUM_LANES);
      hit_s       = !win_found_s && lane_valid[cand_s] && (rem_r[cand_s] != '0);
      win_lane_s  = hit_s ? cand_s : win_lane_s;
      win_found_s = win_found_s | hit_s;
    end
  end

  // a word start spends one credit; a pop returns one, saturating at the buffer depth
  always_comb begin
    credit_dec_s = transfer_s && (idx_r == '0);
    case ({word_consumed, credit_dec_s})
      2'b10:   credit_next_s = (credit_r != CRED_MAX) ? credit_r + CRED_W'(1) : credit_r;
      2'b01:   credit_next_s = credit_r - CRED_W'(1);
      default: credit_next_s = credit_r;
    endcase
  end

  // layer sequencing FSM with grant lock and registered packer outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= ST_IDLE;
      for (int i = 0; i < NUM_LANES; i++) rem_r[i] <= '0;
      idx_r             <= '0;
      credit_r          <= CRED_MAX;
      rr_ptr_r          <= '0;
      grant_r           <= '0;
      grant_valid_r     <= 1'b0;
      pk_operation_r    <= 2'b00;
      pk_in_valid_r     <= 1'b0;
      pk_in_data_r      <= 1'b0;
      pk_layer_finish_r <= 1'b0;
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
    end else begin
      credit_r          <= credit_next_s;
      pk_in_valid_r     <= 1'b0;
      pk_in_data_r      <= 1'b0;
      pk_layer_finish_r <= 1'b0;
      done_r            <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cfg_start) begin
            for (int i = 0; i < NUM_LANES; i++) rem_r[i] <= cfg_bits_per_lane;
            pk_operation_r <= cfg_operation;
            busy_r         <= 1'b1;
            grant_valid_r  <= 1'b0;
            state_r        <= (cfg_bits_per_lane == '0) ? ST_FLUSH : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (all_zero_s) begin
            grant_valid_r <= 1'b0;
`ifdef PSUM_SCHED_PAD_EN
            state_r       <= (idx_r != '0) ? ST_PAD : ST_FLUSH;
`else
            state_r       <= ST_FLUSH;
`endif
          end else if (!grant_valid_r) begin
            if (win_found_s) begin
              grant_r       <= win_lane_s;
              grant_valid_r <= 1'b1;
              rr_ptr_r      <= (win_lane_s == LANE_LAST) ? '0 : win_lane_s + LANE_W'(1);
            end
          end else if (transfer_s) begin
            rem_r[grant_r] <= rem_r[grant_r] - LEN_WIDTH'(1);
            idx_r          <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
            pk_in_valid_r  <= 1'b1;
            pk_in_data_r   <= bit_s;
            // release at word end or lane exhaustion; a mid-word release keeps filling the word
            if ((idx_r == IDX_LAST) || (rem_r[grant_r] == LEN_WIDTH'(1))) grant_valid_r <= 1'b0;
          end
        end
`ifdef PSUM_SCHED_PAD_EN
        ST_PAD: begin
          pk_in_valid_r <= 1'b1;
          idx_r         <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
          if (idx_r == IDX_LAST) state_r <= ST_FLUSH;
        end
`endif
        ST_FLUSH: begin
          state_r <= ST_FINISH;
        end
        ST_FINISH: begin
          pk_layer_finish_r <= 1'b1;
          done_r            <= 1'b1;
          busy_r            <= 1'b0;
          idx_r             <= '0;
          state_r           <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign lane_ready      = lane_ready_s;
  assign pk_operation    = pk_operation_r;
  assign pk_in_valid     = pk_in_valid_r;
  assign pk_in_data      = pk_in_data_r;
  assign pk_layer_finish = pk_layer_finish_r;
  assign busy            = busy_r;
  assign done            = done_r;

endmodule

// File: tb/tb_psum_out_scheduler.sv
// Scoreboard bench for psum_out_scheduler: expected packer bits queued at stimulus time.
module tb_psum_out_scheduler;

  localparam int NL = 4;
  localparam int WB = 32;
  localparam int CD = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [1:0]    cfg_operation = 2'b00;
  logic [LW-1:0] cfg_bits = '0;
  logic [NL-1:0] lane_valid = '0;
  logic [NL-1:0] lane_data = '0;
  logic [NL-1:0] lane_ready;
  logic          word_consumed = 1'b0;
  logic [1:0]    pk_operation;
  logic          pk_in_valid, pk_in_data, pk_layer_finish, busy, done;

  int   vectors = 0;
  int   miscompares = 0;
  logic exp_q[$];
  int   sent[NL];
  int   n_bits, n_finish, n_done, cyc, last_valid_cyc, finish_cyc;
  logic [NL-1:0] vmask;
  logic start_pend, consume_pend;

  always #5 clk = ~clk;

  psum_out_scheduler #(.NUM_LANES(NL), .WORD_BITS(WB), .CREDIT_DEPTH(CD), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_operation(cfg_operation),
    .cfg_bits_per_lane(cfg_bits), .lane_valid(lane_valid), .lane_data(lane_data),
    .lane_ready(lane_ready), .word_consumed(word_consumed), .pk_operation(pk_operation),
    .pk_in_valid(pk_in_valid), .pk_in_data(pk_in_data), .pk_layer_finish(pk_layer_finish),
    .busy(busy), .done(done)
  );

  function automatic logic pat(input int l, input int k);
    logic [31:0] v;
    v = 32'(k * (2 * l + 3) + l * 5);
    return v[0] ^ v[2] ^ v[4];
  endfunction

  task automatic push_lane(input int l, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) exp_q.push_back(pat(l, k));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_start = 1'b0; word_consumed = 1'b0; lane_valid = '0; lane_data = '0;
    start_pend = 1'b0; consume_pend = 1'b0; vmask = '0;
    for (int l = 0; l < NL; l++) sent[l] = 0;
    n_bits = 0; n_finish = 0; n_done = 0; cyc = 0; last_valid_cyc = 0; finish_cyc = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one cycle: sample outputs on the falling edge, score packer bits, then drive inputs
  task automatic step();
    logic exp_b;
    @(negedge clk);
    cyc++;
    vectors++;
    if (!$onehot0(lane_ready)) begin
      miscompares++;
      $display("FAIL lane_ready_onehot got %b", lane_ready);
    end
    if (pk_in_valid) begin
      n_bits++;
      last_valid_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL extra_bit got %b expected no bit", pk_in_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (pk_in_data !== exp_b) begin
          miscompares++;
          $display("FAIL bit_%0d got %b expected %b", n_bits, pk_in_data, exp_b);
        end
      end
    end
    if (pk_layer_finish) begin n_finish++; finish_cyc = cyc; end
    if (done) n_done++;
    cfg_start = start_pend; start_pend = 1'b0;
    word_consumed = consume_pend; consume_pend = 1'b0;
    lane_valid = vmask;
    for (int l = 0; l < NL; l++) begin
      lane_data[l] = pat(l, sent[l]);
      if (lane_valid[l] && lane_ready[l]) sent[l]++;
    end
  endtask

  task automatic run_until_done(input int budget, input bit keep_consume, output bit timed_out);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      consume_pend = keep_consume;
      step();
      k++;
    end
    timed_out = (n_done == 0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    do_reset();
    step();
    vectors++;
    if ({pk_in_valid, pk_in_data, pk_layer_finish, busy, done} !== 5'b0 || lane_ready !== '0 || pk_operation !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_outputs got v%b d%b f%b b%b dn%b r%b op%b expected all 0",
               pk_in_valid, pk_in_data, pk_layer_finish, busy, done, lane_ready, pk_operation);
    end
    vectors++;
    if (dut.credit_r !== 4'(CD)) begin miscompares++; $display("FAIL reset_credit got %0d expected %0d", dut.credit_r, CD); end
  endtask

  task automatic test_round_robin();
    bit to;
    do_reset();
    for (int l = 0; l < NL; l++) push_lane(l, 0, 31);
    cfg_bits = 16'd32; cfg_operation = 2'd2; vmask = 4'hF; start_pend = 1'b1;
    step();
    step();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL rr_busy got %b expected 1", busy); end
    run_until_done(2000, 1'b0, to);
    vectors++; if (to) begin miscompares++; $display("FAIL rr_timeout got no done expected done"); end
    vectors++; if (n_bits != 128) begin miscompares++; $display("FAIL rr_bits got %0d expected 128", n_bits); end
    vectors++; if (n_finish != 1) begin miscompares++; $display("FAIL rr_finish got %0d expected 1", n_finish); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rr_leftover got %0d expected 0", exp_q.size()); end
    vectors++; if (dut.credit_r !== 4'd4) begin miscompares++; $display("FAIL rr_credit got %0d expected 4", dut.credit_r); end
    vectors++; if (pk_operation !== 2'd2) begin miscompares++; $display("FAIL rr_operation got %0d expected 2", pk_operation); end
  endtask

  task automatic test_mid_word_switch();
    int k;
    do_reset();
    push_lane(1, 0, 39); push_lane(2, 0, 23); push_lane(3, 0, 31); push_lane(0, 0, 31);
    push_lane(2, 24, 39); push_lane(3, 32, 39); push_lane(0, 32, 39);
    cfg_bits = 16'd40; cfg_operation = 2'd0; vmask = 4'h2; start_pend = 1'b1;
    step();
    k = 0;
    while (n_done == 0 && k < 2000) begin
      vmask = (sent[1] >= 40) ? 4'hF : 4'h2;
      step();
      k++;
    end
    vectors++; if (n_done == 0) begin miscompares++; $display("FAIL mix_timeout got no done expected done"); end
    vectors++; if (n_bits != 160) begin miscompares++; $display("FAIL mix_bits got %0d expected 160", n_bits); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL mix_leftover got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_credit_stall();
    bit to;
    do_reset();
    for (int l = 0; l < NL; l++) push_lane(l, 0, 31);
    for (int l = 0; l < NL; l++) push_lane(l, 32, 63);
    cfg_bits = 16'd96; vmask = 4'hF; start_pend = 1'b1;
    repeat (400) step();
    vectors++; if (n_bits != 256) begin miscompares++; $display("FAIL credit_bits got %0d expected 256", n_bits); end
    vectors++; if (lane_ready !== '0) begin miscompares++; $display("FAIL credit_stall_ready got %b expected 0", lane_ready); end
    vectors++; if (dut.credit_r !== 4'd0) begin miscompares++; $display("FAIL credit_zero got %0d expected 0", dut.credit_r); end
    push_lane(0, 64, 95);
    consume_pend = 1'b1;
    repeat (100) step();
    vectors++; if (n_bits != 288) begin miscompares++; $display("FAIL credit_one_word got %0d expected 288", n_bits); end
    vectors++; if (lane_ready !== '0) begin miscompares++; $display("FAIL credit_restall_ready got %b expected 0", lane_ready); end
    for (int l = 1; l < NL; l++) push_lane(l, 64, 95);
    run_until_done(2000, 1'b1, to);
    vectors++; if (to) begin miscompares++; $display("FAIL credit_timeout got no done expected done"); end
    vectors++; if (n_bits != 384) begin miscompares++; $display("FAIL credit_total got %0d expected 384", n_bits); end
    vectors++; if (dut.credit_r !== 4'(CD)) begin miscompares++; $display("FAIL credit_sat got %0d expected %0d", dut.credit_r, CD); end
  endtask

  task automatic test_zero_length();
    do_reset();
    cfg_bits = 16'd0; vmask = 4'hF; start_pend = 1'b1;
    step();
    for (int c = 1; c <= 6; c++) begin
      step();
      vectors++;
      if (pk_layer_finish !== (c == 3) || done !== (c == 3) || busy !== (c == 1 || c == 2)) begin
        miscompares++;
        $display("FAIL zero_len_cycle%0d got fin%b done%b busy%b expected fin%b done%b busy%b", c,
                 pk_layer_finish, done, busy, c == 3, c == 3, c == 1 || c == 2);
      end
    end
    vectors++; if (n_bits != 0) begin miscompares++; $display("FAIL zero_len_bits got %0d expected 0", n_bits); end
  endtask

  task automatic test_partial_word();
    bit to;
    int exp_bits;
    do_reset();
    for (int l = 0; l < NL; l++) push_lane(l, 0, 9);
`ifdef PSUM_SCHED_PAD_EN
    for (int i = 0; i < 24; i++) exp_q.push_back(1'b0);
    exp_bits = 64;
`else
    exp_bits = 40;
`endif
    cfg_bits = 16'd10; vmask = 4'hF; start_pend = 1'b1;
    step();
    run_until_done(1000, 1'b0, to);
    vectors++; if (to) begin miscompares++; $display("FAIL partial_timeout got no done expected done"); end
    vectors++; if (n_bits != exp_bits) begin miscompares++; $display("FAIL partial_bits got %0d expected %0d", n_bits, exp_bits); end
    vectors++; if (n_finish != 1) begin miscompares++; $display("FAIL partial_finish got %0d expected 1", n_finish); end
    vectors++;
    if (finish_cyc <= last_valid_cyc) begin
      miscompares++;
      $display("FAIL partial_order got finish@%0d last_bit@%0d expected finish after bits", finish_cyc, last_valid_cyc);
    end
  endtask

  task automatic test_async_reset();
    bit to;
    do_reset();
    cfg_bits = 16'd32; vmask = 4'hF; start_pend = 1'b1;
    push_lane(0, 0, 31);
    repeat (20) step();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_pre_busy got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({pk_in_valid, pk_in_data, pk_layer_finish, busy, done} !== 5'b0 || lane_ready !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs got v%b d%b f%b b%b dn%b r%b expected all 0",
               pk_in_valid, pk_in_data, pk_layer_finish, busy, done, lane_ready);
    end
    vectors++; if (dut.credit_r !== 4'(CD)) begin miscompares++; $display("FAIL abort_credit got %0d expected %0d", dut.credit_r, CD); end
    do_reset();
    for (int l = 0; l < NL; l++) push_lane(l, 0, 31);
    cfg_bits = 16'd32; vmask = 4'hF; start_pend = 1'b1;
    step();
    run_until_done(2000, 1'b0, to);
    vectors++; if (to || n_done != 1) begin miscompares++; $display("FAIL restart_done got %0d expected 1", n_done); end
    vectors++; if (n_bits != 128) begin miscompares++; $display("FAIL restart_bits got %0d expected 128", n_bits); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_mid_word_switch();
    test_credit_stall();
    test_zero_length();
    test_partial_word();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/psum_out_scheduler.md
Name: psum_out_scheduler

Overview:
- Word-granular round-robin arbiter and sequencer feeding the 1-bit psum output packer (32-bit AXIS word builder).
- Drains NUM_LANES PE result lanes, each producing a configured number of 1-bit psums per layer, into the packer's single bit stream.
- Throttles word starts against downstream word credits and terminates each layer with a clean layer_finish pulse.

Parameters:
- NUM_LANES, 4: number of requesting PE lanes.
- WORD_BITS, 32: bits per packed output word; must match the packer's TDATA width.
- CREDIT_DEPTH, 8: downstream word buffer depth; the credit counter's initial and maximum value.
- LEN_WIDTH, 16: width of the per-lane bit count.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse that starts a layer; ignored while busy
- cfg_operation  in  2  layer operation code, latched on cfg_start
- cfg_bits_per_lane  in  LEN_WIDTH  psum bits per lane for this layer, latched on cfg_start
- lane_valid  in  NUM_LANES  per-lane bit valid
- lane_data  in  NUM_LANES  per-lane psum bit
- lane_ready  out  NUM_LANES  per-lane accept; at most one bit set (one-hot or zero)
- word_consumed  in  1  downstream popped one word; returns one credit
- pk_operation  out  2  latched operation code, driven to the packer
- pk_in_valid  out  1  packer bit valid
- pk_in_data  out  1  packer bit
- pk_layer_finish  out  1  one-cycle layer-end pulse to the packer
- busy  out  1  high from the cycle after cfg_start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; FSM to IDLE; credit = CREDIT_DEPTH; rr_ptr = 0; shadow bit index = 0; all lane remaining counters = 0.
- FSM states:
  - IDLE: cfg_start loads every lane's remaining count with cfg_bits_per_lane and latches the operation; next state is ISSUE, or FLUSH if cfg_bits_per_lane = 0.
  - ISSUE: transfers bits. Exits to FLUSH when all remaining counters are 0.
  - FLUSH: one cycle with pk_in_valid = 0.
  - FINISH: pk_layer_finish = 1 for one cycle, done = 1 for one cycle, then IDLE.
- Grant:
  - Taken when shadow index = 0, or when the granted lane's remaining count reaches 0 mid-word.
  - Winner is the first lane from rr_ptr (wrapping) with remaining > 0 and lane_valid = 1.
  - If no lane qualifies, stall with no grant.
  - On each new grant, rr_ptr = granted lane + 1 mod NUM_LANES.
- Grant lock: the grant holds until the word completes (index wraps to 0) or the lane is exhausted; a mid-word switch keeps filling the same word.
- lane_ready[g] = ISSUE && granted && remaining[g] > 0 && (index != 0 || credit > 0).
- Transfer occurs when lane_valid[g] && lane_ready[g]. On a transfer:
  - remaining[g] decrements.
  - Index increments mod WORD_BITS.
  - If index was 0, credit decrements.
- Packer outputs are registered: pk_in_valid/pk_in_data equal the transfer and its bit one cycle later (latency 1).
- Gaps between bits of a word are permitted.
- Credit rules:
  - word_consumed increments credit.
  - Simultaneous increment and decrement leaves credit unchanged.
  - word_consumed at credit = CREDIT_DEPTH is ignored (saturates).
- Zero credit at index 0: stall; lane_ready = 0.
- Partial final word: with no pad, pk_layer_finish resets the packer's word pointer. cfg_operation = 0 emits the partial word; other operations drop it.
- Shadow index is cleared to 0 in FINISH. rr_ptr persists across layers.
- Async reset mid-layer aborts immediately with no done pulse; the next cfg_start starts cleanly.

Optional Feature:
- Macro PSUM_SCHED_PAD_EN.
- Defined: at ISSUE exit with index != 0, enter PAD before FLUSH. PAD drives pk_in_valid = 1 and pk_in_data = 0 for (WORD_BITS - index) cycles, with no lanes granted and no extra credit taken (already charged at word start).
- Not defined: no PAD state; the partial word is handled by the packer as above.

Test Plan:
- NUM_LANES=4, 32 bits/lane, all lanes valid, credit 8 → words alternate lanes 0,1,2,3, each word 32 bits from one lane; 128 pk_in_valid; one pk_layer_finish; done; credit ends 4.
- Lane 1 bits_per_lane=40, other lanes idle/exhausted pattern (cfg 40, lanes 0/2/3 valid low until lane 1 done) → word 2 mixes lane 1's last 8 bits with the next qualifying lane's bits; no grant loss.
- CREDIT_DEPTH=2, word_consumed held 0 → exactly 64 bits transferred then lane_ready = 0; one word_consumed pulse → exactly 32 more bits.
- cfg_bits_per_lane=0 → no pk_in_valid; pk_layer_finish at cycle 3 after cfg_start; done the same cycle.
- 4 lanes × 10 bits (40 total) → with PSUM_SCHED_PAD_EN, 24 zero pad bits before pk_layer_finish; without it, layer_finish follows 40 bits plus one FLUSH cycle.
- rst_n asserted mid-ISSUE → all outputs 0 within the same cycle, credit = CREDIT_DEPTH; a new cfg_start then completes normally.
